// File: rtl/spi_master.sv
// spi_master: single-byte SPI master, MSB first, mode selected by MODE={CPOL,CPHA}.
//
// Ports
//   CLK        system clock, all logic on posedge
//   reset      synchronous active-high reset
//   start      transfer request, sampled only while busy=0
//   data_in    byte to transmit, latched when start is accepted
//   MISO       serial data from the slave
//   SCLK       SPI clock (idles at CPOL)
//   MOSI       serial data to the slave
//   CS         chip select, active low
//   busy       high from start acceptance until the done cycle
//   done       one-cycle pulse when rx is valid
//   rx         last received byte
//   state_dbg  current FSM state encoding, for observation only
//
// Handshake: start is a level request. It is accepted on any posedge where
// busy=0 (IDLE or the DONE cycle); data_in is captured on that same edge.
// While busy=1 start is ignored. done pulses for exactly one cycle, in the
// same cycle busy falls, and rx is valid from that cycle until the next done
// or reset.
module spi_master #(
  parameter logic [1:0] MODE     = 2'd2,
  parameter int         HALF_DIV = 4,
  parameter int         CS_GAP   = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       MISO,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx,
  output logic [2:0] state_dbg
);

  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];

  // One counter serves both the CS gaps and the SCLK half-periods.
  localparam int CNT_MAX = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HD_LAST  = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       edge_cnt, edge_cnt_n;   // SCLK edges already produced
  logic [7:0]       tx_shift, tx_shift_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             sclk_n, mosi_n, cs_n, busy_n, done_n;
  logic [7:0]       rx_n;
  logic             leading;                // next edge is a leading edge

  // Edges 1,3,..,15 are leading; edge_cnt counts completed edges, so the
  // upcoming edge is leading when edge_cnt is even.
  assign leading   = ~edge_cnt[0];
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      SCLK     <= CPOL;
      MOSI     <= 1'b0;
      CS       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx       <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      edge_cnt <= edge_cnt_n;
      tx_shift <= tx_shift_n;
      rx_shift <= rx_shift_n;
      SCLK     <= sclk_n;
      MOSI     <= mosi_n;
      CS       <= cs_n;
      busy     <= busy_n;
      done     <= done_n;
      rx       <= rx_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    edge_cnt_n = edge_cnt;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    sclk_n     = SCLK;
    mosi_n     = MOSI;
    cs_n       = CS;
    busy_n     = busy;
    done_n     = 1'b0;
    rx_n       = rx;

    case (state)
      // DONE behaves like IDLE for start acceptance, which gives a single
      // CS-high cycle between back-to-back transfers.
      IDLE, DONE: begin
        sclk_n  = CPOL;
        cs_n    = 1'b1;
        mosi_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
        if (start) begin
          state_n    = SETUP;
          cnt_n      = '0;
          edge_cnt_n = '0;
          tx_shift_n = data_in;
          rx_shift_n = '0;
          cs_n       = 1'b0;
          busy_n     = 1'b1;
          // CPHA=0 must present bit 7 before the first (sampling) edge.
          mosi_n     = (CPHA == 1'b0) ? data_in[7] : 1'b0;
        end
      end

      SETUP: begin
        if (cnt == GAP_LAST) begin
          state_n = XFER;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      XFER: begin
        if (cnt == HD_LAST) begin
          cnt_n      = '0;
          sclk_n     = ~SCLK;
          edge_cnt_n = edge_cnt + 1'b1;
          // MISO is taken on the CLK edge that toggles SCLK, i.e. the value
          // present just before the SCLK edge.
          if (CPHA == 1'b0) begin
            if (leading) begin
              rx_shift_n = {rx_shift[6:0], MISO};
            end else if (edge_cnt != 4'd15) begin
              // bit 7 went out with CS; trailing edges 2..14 send bits 6..0
              mosi_n     = tx_shift[6];
              tx_shift_n = {tx_shift[6:0], 1'b0};
            end
          end else begin
            if (leading) begin
              mosi_n     = tx_shift[7];
              tx_shift_n = {tx_shift[6:0], 1'b0};
            end else begin
              rx_shift_n = {rx_shift[6:0], MISO};
            end
          end
          if (edge_cnt == 4'd15) begin
            state_n = HOLD;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      HOLD: begin
        if (cnt == GAP_LAST) begin
          state_n = DONE;
          cnt_n   = '0;
          cs_n    = 1'b1;
          mosi_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          rx_n    = rx_shift;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: five instances (MODE 0..3 with defaults, plus MODE 1
// with HALF_DIV=1/CS_GAP=1) share start/data_in/reset. Each instance gets
// either a loopback MISO or a behavioural SPI slave driven by SCLK edges.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       lb;          // 1: MISO = MOSI, 0: MISO from slave model
  logic [7:0] slv_byte;    // byte the slave model shifts out
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int inst, bit ok, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s [inst %0d] cyc=%0d: got 0x%0h expected 0x%0h", name, inst, cyc, act, exp);
    end
  endtask

  // ---------------- DUTs, slaves, monitors ----------------
  for (genvar g = 0; g < 5; g++) begin : gi
    localparam int   MI  = (g == 4) ? 1 : g;
    localparam int   HD  = (g == 4) ? 1 : 4;
    localparam int   CG  = (g == 4) ? 1 : 2;
    localparam int   N   = 2 * CG + 16 * HD + 1;
    localparam logic [1:0] M = 2'(MI);
    localparam logic CP  = M[1];
    localparam logic CPH = M[0];

    logic       sclk, mosi, cs, busy, done, miso;
    logic [7:0] rx;
    logic [2:0] st;
    logic       s_miso = 1'b0;

    assign miso = lb ? mosi : s_miso;

    spi_master #(.MODE(M), .HALF_DIV(HD), .CS_GAP(CG)) u_dut (
      .CLK(clk), .reset(reset), .start(start), .data_in(data_in), .MISO(miso),
      .SCLK(sclk), .MOSI(mosi), .CS(cs), .busy(busy), .done(done), .rx(rx),
      .state_dbg(st)
    );

    // scoreboard queues
    logic [7:0] exp_q[$];   // expected rx per accepted transfer
    int         dq[$];      // cycle index at which done must be seen
    logic [7:0] cap_q[$];   // byte the slave must capture

    // Behavioural slave: loads its byte when CS falls, samples MOSI on the
    // mode's sampling edge and shifts its next bit out on the other edge.
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
    int         s_n = 0;

    always @(negedge cs) begin
      s_tx = slv_byte;
      s_rx = 8'h00;
      s_n  = 0;
      if (!CPH) begin
        s_miso = s_tx[7];
        s_tx   = {s_tx[6:0], 1'b0};
      end
    end

    always @(sclk) begin
      if (cs === 1'b0 && (sclk === 1'b0 || sclk === 1'b1)) begin
        if ((sclk != CP) == !CPH) begin
          s_rx = {s_rx[6:0], mosi};
          s_n++;
        end else begin
          s_miso = s_tx[7];
          s_tx   = {s_tx[6:0], 1'b0};
        end
      end
    end

    always @(posedge cs) begin
      logic [7:0] e;
      if (cap_q.size() > 0) begin
        e = cap_q.pop_front();
        check("slave_rx", g, (s_rx == e) && (s_n == 8), {s_n[7:0], s_rx}, {8'd8, e});
      end
    end

    // Monitor: reference model of acceptance/busy/timing plus output checks.
    int   next_ok = 0, last_p = 0, tog = 0;
    int   mosi_chg = -1000, samp = -1000;
    logic prev_rst = 1'b0, prev_cs = 1'b1, prev_sclk = CP, prev_mosi = 1'b0;
    logic armed = 1'b0, abort_mon = 1'b0;

    always @(negedge clk) begin
      logic exp_busy;
      int   p, d;
      if (prev_rst) begin
        armed = 1'b1;
        check("rst_cs",   g, cs === 1'b1,   32'(cs),   32'd1);
        check("rst_sclk", g, sclk === CP,   32'(sclk), 32'(CP));
        check("rst_busy", g, busy === 1'b0, 32'(busy), 32'd0);
        check("rst_done", g, done === 1'b0, 32'(done), 32'd0);
        check("rst_rx",   g, rx === 8'h00,  32'(rx),   32'd0);
      end
      if (reset) begin
        exp_q.delete();
        dq.delete();
        cap_q.delete();
        next_ok   = cyc + 2;
        abort_mon = (cs === 1'b0);
      end else if (armed) begin
        exp_busy = (cyc >= last_p) && (cyc < next_ok - 1);
        check("busy", g, busy === exp_busy,  32'(busy), 32'(exp_busy));
        check("cs",   g, cs === !exp_busy,   32'(cs),   32'(!exp_busy));

        if (prev_cs === 1'b1 && cs === 1'b0) begin
          check("idle_before", g, sclk === CP, 32'(sclk), 32'(CP));
          tog      = 0;
          samp     = -1000;
          mosi_chg = cyc;
        end else if (cs === 1'b0) begin
          if (sclk !== prev_sclk) begin
            tog++;
            if ((sclk !== CP) == !CPH) begin
              check("mosi_setup", g, (cyc - mosi_chg) >= HD, 32'(cyc - mosi_chg), 32'(HD));
              samp = cyc;
            end
          end
          if (mosi !== prev_mosi) begin
            check("mosi_hold", g, (cyc - samp) >= HD, 32'(cyc - samp), 32'(HD));
            mosi_chg = cyc;
          end
        end else if (prev_cs === 1'b0 && cs === 1'b1) begin
          if (abort_mon) begin
            abort_mon = 1'b0;
          end else begin
            check("toggles",    g, tog == 16,   32'(tog),  32'd16);
            check("idle_after", g, sclk === CP, 32'(sclk), 32'(CP));
          end
        end

        if (done === 1'b1) begin
          check("done_expected", g, dq.size() > 0, 32'(dq.size()), 32'd1);
          if (dq.size() > 0) begin
            d = dq.pop_front();
            check("rx", g, rx === exp_q[0], 32'(rx), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            check("latency", g, cyc == d, 32'(cyc - d + N), 32'(N));
          end
        end
        while (dq.size() > 0 && dq[0] < cyc) begin
          check("done_missing", g, 1'b0, 32'(dq[0]), 32'(cyc));
          void'(dq.pop_front());
          void'(exp_q.pop_front());
        end

        if (start === 1'b1 && (cyc + 1) >= next_ok) begin
          p = cyc + 1;
          exp_q.push_back(lb ? data_in : slv_byte);
          dq.push_back(p + N - 1);
          cap_q.push_back(data_in);
          last_p  = p;
          next_ok = p + N;
        end
      end
      prev_rst  = reset;
      prev_cs   = cs;
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(logic [7:0] d);
    start   = 1'b1;
    data_in = d;
    tick(1);
    start   = 1'b0;
    data_in = 8'($urandom);   // changes after acceptance must not matter
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    data_in  = 8'h00;
    lb       = 1'b1;
    slv_byte = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(2);

    // loopback, 0xB3
    pulse_start(8'hB3);
    tick(72);

    // slave model returns 0x5A, master sends 0xC3
    lb       = 1'b0;
    slv_byte = 8'h5A;
    pulse_start(8'hC3);
    tick(72);

    // second start 10 cycles in is ignored
    lb = 1'b1;
    pulse_start(8'($urandom));
    tick(9);
    pulse_start(8'hFF);
    tick(72);

    // reset on the CLK edge that would produce SCLK edge 7
    pulse_start(8'($urandom));
    tick(29);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    pulse_start(8'h3C);
    tick(72);

    // back-to-back with start held through the done cycle
    start   = 1'b1;
    data_in = 8'h81;
    tick(1);
    data_in = 8'h7E;
    tick(69);
    start   = 1'b0;
    tick(72);

    // randomized transfers
    for (int i = 0; i < 8; i++) begin
      lb       = 1'($urandom_range(0, 1));
      slv_byte = 8'($urandom);
      pulse_start(8'($urandom));
      tick($urandom_range(70, 78));
    end

    tick(10);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI master. It is the initiating end for the team's SPI slave: it drives CS, SCLK and MOSI, and captures MISO.
- Mode is set by a CPOL/CPHA parameter and matches the slave's mode encoding.
- Data is MSB first.
- Sits between the host-side control logic (start/data_in/rx/done) and the SPI pins.

Parameters:
- MODE, 2'd2, {CPOL, CPHA}. CPOL is the SCLK idle level. CPHA=0 samples on leading edges; CPHA=1 samples on trailing edges.
- HALF_DIV, 4, CLK cycles per SCLK half-period. Legal range is 1 or more.
- CS_GAP, 2, CLK cycles CS is low before the first SCLK edge and after the last SCLK edge. Legal range is 1 or more.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a transfer; sampled only while busy=0.
- data_in  input  8  byte to transmit; latched when start is accepted.
- MISO  input  1  serial data from the slave.
- SCLK  output  1  SPI clock.
- MOSI  output  1  serial data to the slave.
- CS  output  1  chip select, active low.
- busy  output  1  high from start acceptance until the done cycle.
- done  output  1  one-cycle pulse when rx is valid.
- rx  output  8  last received byte.

Behaviour:
- Reset (reset=1 at posedge CLK):
  - Next-cycle outputs: SCLK=CPOL, CS=1, MOSI=0, busy=0, done=0, rx=8'h00.
  - Shift registers and counters are cleared; state goes to IDLE.
  - Reset takes priority over all other inputs, including mid-transfer. An aborted transfer produces no done pulse and leaves rx at 0.
- States: IDLE, SETUP, XFER, HOLD, DONE.
- IDLE:
  - SCLK=CPOL, CS=1, MOSI=0.
  - start=1 at posedge: latch data_in into tx_shift, set CS=0 and busy=1, go to SETUP.
- SETUP (CS_GAP cycles):
  - CPHA=0: MOSI=data_in[7] from the same edge CS falls.
  - CPHA=1: MOSI holds 0 until the first SCLK edge.
  - Then go to XFER.
- XFER (16 SCLK edges, one toggle every HALF_DIV cycles):
  - Edges are numbered 1..16; odd edges are leading, even edges are trailing.
  - CPHA=0: on odd edges, shift MISO into rx_shift LSB. On even edges 2..14, drive the next tx bit; edge 16 does not change MOSI.
  - CPHA=1: on odd edges, drive the tx bit (bit7 first). On even edges, sample MISO.
  - MISO is sampled at the posedge CLK on which SCLK toggles (the pre-toggle value is used).
  - After edge 16, SCLK=CPOL; go to HOLD.
- HOLD (CS_GAP cycles): CS stays 0, SCLK=CPOL, MOSI holds its last value. Then go to DONE.
- DONE (1 cycle):
  - CS=1, MOSI=0, busy=0, done=1, rx=rx_shift.
  - Returns to IDLE, but start is sampled in this cycle too: start=1 here begins a new transfer on the next posedge, so CS is high for exactly 1 cycle.
- Timing: done is high exactly 2*CS_GAP + 16*HALF_DIV + 1 CLK cycles after the posedge that accepted start. With defaults this is 69 cycles.
- Transfers are bit-exact: 8 bits out, 8 bits in, MSB first.
- Input handling:
  - start while busy=1 (SETUP/XFER/HOLD) is ignored; there is no queueing.
  - data_in changes after acceptance have no effect.
- rx holds its value until the next DONE or reset.

Test Plan:
- MODE=2, defaults, MISO tied to MOSI (loopback); pulse start with data_in=8'hB3.
  - MOSI sequence at sample edges: 1,0,1,1,0,0,1,1.
  - Exactly 16 SCLK toggles; SCLK idles at 1.
  - done is high for 1 cycle, 69 cycles after start; rx=8'hB3; busy falls with done.
- Each of MODE 0..3, with a bench slave model that shifts out 8'h5A on the opposite edge; data_in=8'hC3.
  - rx=8'h5A.
  - Slave captures 8'hC3.
  - MOSI is stable for HALF_DIV cycles around every sampling edge.
  - SCLK idle equals CPOL before and after the transfer.
- Pulse start again 10 cycles into a transfer with data_in=8'hFF.
  - Ignored: there is no restart, rx matches the first byte, and only one done pulse occurs.
- Assert reset for 1 cycle at edge 7 of a transfer.
  - Next cycle: CS=1, SCLK=CPOL, busy=0, rx=0.
  - No done pulse.
  - A subsequent start with 8'h3C completes normally.
- Back-to-back: hold start=1 through the done cycle, with data_in=8'h81 then 8'h7E.
  - CS is high for exactly 1 cycle between transfers.
  - Two done pulses occur 69 cycles apart.
  - Loopback rx is 8'h81, then 8'h7E.
- HALF_DIV=1, CS_GAP=1, MODE=1, loopback with 8'h55.
  - SCLK toggles every CLK cycle.
  - done occurs 19 cycles after start; rx=8'h55.
